// File: rtl/throughout_mon_pkg.sv
// Shared types for the throughout monitor: FSM states, failure reasons and
// the width of the beat counter.
package throughout_mon_pkg;

    localparam int BEAT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        NO_B_ROSE = 2'd1,
        A_DROP    = 2'd2,
        C_LOW     = 2'd3
    } fail_code_e;

endpackage

// File: rtl/throughout_monitor_rose_detect.sv
// Rising-edge detector: remembers the previous sample of x_i and flags a 0->1 change.
module rose_detect (
    input  logic clk,
    input  logic rst,
    input  logic x_i,
    output logic rose_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= x_i;
        end
    end

    assign rose_o = x_i & ~prev_q;

endmodule

// File: rtl/throughout_monitor.sv
// Checks that after a joint rise of a and b, c stays high for BURST_LEN cycles
// while a stays high; reports registered pass/fail pulses and saturating counts.
module throughout_monitor
    import throughout_mon_pkg::*;
#(
    parameter int BURST_LEN = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             busy,
    output logic             pass_pulse,
    output logic             fail_pulse,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count
);

    localparam logic [BEAT_W-1:0] BURST_B = BEAT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d, beat_inc;
    fail_code_e        code_q, code_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [CNT_W-1:0]  pass_cnt_q, fail_cnt_q;
    logic              a_rose, b_rose;

    rose_detect u_rose_a (.clk(clk), .rst(rst), .x_i(a), .rose_o(a_rose));
    rose_detect u_rose_b (.clk(clk), .rst(rst), .x_i(b), .rose_o(b_rose));

    assign beat_inc = beat_q + 4'd1;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        code_d  = code_q;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_rose) begin
                    if (b_rose) begin
                        state_d = CHECK;
                        beat_d  = '0;
                    end else begin
                        fail_d = 1'b1;
                        code_d = NO_B_ROSE;
                    end
                end
            end
            CHECK: begin
                // a dropping outranks c dropping in the same sample
                if (!a) begin
                    fail_d  = 1'b1;
                    code_d  = A_DROP;
                    state_d = IDLE;
                    beat_d  = '0;
                end else if (!c) begin
                    fail_d  = 1'b1;
                    code_d  = C_LOW;
                    state_d = IDLE;
                    beat_d  = '0;
                end else if (beat_inc == BURST_B) begin
                    pass_d  = 1'b1;
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_inc;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            code_q     <= NONE;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            code_q  <= code_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            if (pass_d && (pass_cnt_q != CNT_MAX)) begin
                pass_cnt_q <= pass_cnt_q + CNT_ONE;
            end
            if (fail_d && (fail_cnt_q != CNT_MAX)) begin
                fail_cnt_q <= fail_cnt_q + CNT_ONE;
            end
        end
    end

    assign busy       = (state_q == CHECK);
    assign pass_pulse = pass_q;
    assign fail_pulse = fail_q;
    assign fail_code  = code_q;
    assign pass_count = pass_cnt_q;
    assign fail_count = fail_cnt_q;

endmodule

// File: tb/tb_throughout_monitor.sv
// Bench for throughout_monitor with BURST_LEN=2, CNT_W=2: scenario tasks plus a
// scoreboard that pairs every result pulse with the expectation queued at stimulus time.
module tb_throughout_monitor;

    localparam int BL = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a = 1'b0;
    logic          b = 1'b0;
    logic          c = 1'b0;
    logic          busy;
    logic          pass_pulse;
    logic          fail_pulse;
    logic [1:0]    fail_code;
    logic [CW-1:0] pass_count;
    logic [CW-1:0] fail_count;

    // entry layout: {pass, fail, fail_code, pass_count, fail_count}
    logic [7:0]    exp_q[$];
    logic [7:0]    sb_got;
    logic [7:0]    sb_exp;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [1:0]    exp_pc = 2'd0;
    logic [1:0]    exp_fc = 2'd0;
    logic [1:0]    exp_code = 2'd0;

    throughout_monitor #(.BURST_LEN(BL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .busy(busy), .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
        .fail_code(fail_code), .pass_count(pass_count), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    // scoreboard: every pulse must match the oldest queued expectation
    always @(posedge clk) begin
        #1;
        if (pass_pulse || fail_pulse) begin
            sb_got = {pass_pulse, fail_pulse, fail_code, pass_count, fail_count};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got %b with nothing expected", sb_got);
            end else begin
                sb_exp = exp_q.pop_front();
                if (sb_got !== sb_exp) begin
                    n_fail++;
                    $display("FAIL sb_result: got %b want %b (p,f,code,pc,fc)", sb_got, sb_exp);
                end
            end
        end
    end

    // apply inputs for one sample; returns just after that sample's edge
    task automatic drive(input logic ia, input logic ib, input logic ic);
        a = ia;
        b = ib;
        c = ic;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pass();
        if (exp_pc != 2'd3) exp_pc = exp_pc + 2'd1;
        exp_q.push_back({1'b1, 1'b0, exp_code, exp_pc, exp_fc});
    endtask

    task automatic expect_fail(input logic [1:0] code);
        exp_code = code;
        if (exp_fc != 2'd3) exp_fc = exp_fc + 2'd1;
        exp_q.push_back({1'b0, 1'b1, code, exp_pc, exp_fc});
    endtask

    task automatic run_pass();
        drive(1, 1, 0);
        drive(1, 0, 1);
        expect_pass();
        drive(1, 0, 1);
        drive(0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0);
        drive(0, 0, 0);
        n_checks++;
        if ({busy, pass_pulse, fail_pulse, fail_code, pass_count, fail_count} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%0b p=%0b f=%0b code=%0d pc=%0d fc=%0d want all 0",
                     busy, pass_pulse, fail_pulse, fail_code, pass_count, fail_count);
        end
        rst = 1'b0;
        drive(0, 0, 1);
        drive(0, 1, 1);
        drive(0, 0, 0);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignores_bc: got busy=%0b want 0", busy);
        end
    endtask

    task automatic test_nominal();
        drive(1, 1, 0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_busy: got %0b want 1", busy);
        end
        drive(1, 0, 1);
        expect_pass();
        drive(1, 0, 1);
        n_checks++;
        if ({busy, pass_pulse, pass_count} !== {1'b0, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL nominal_pass: got busy=%0b p=%0b pc=%0d want busy=0 p=1 pc=1",
                     busy, pass_pulse, pass_count);
        end
        drive(1, 0, 0);
        n_checks++;
        if (pass_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_pulse_width: got %0b want 0", pass_pulse);
        end
        drive(0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0);
            drive(1, 0, 1);
            expect_pass();
            drive(1, 0, 1);
            drive(0, 0, 0);
        end
        n_checks++;
        if (pass_count !== 2'd3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want 3", pass_count);
        end
    endtask

    task automatic test_a_drop();
        drive(1, 1, 0);
        drive(1, 0, 1);
        expect_fail(2'd2);
        drive(0, 0, 1);
        n_checks++;
        if ({busy, fail_pulse, fail_code} !== {1'b0, 1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL a_drop: got busy=%0b f=%0b code=%0d want busy=0 f=1 code=2",
                     busy, fail_pulse, fail_code);
        end
        drive(1, 1, 0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL retrigger_busy: got %0b want 1", busy);
        end
        drive(1, 0, 1);
        expect_pass();
        drive(1, 0, 1);
        drive(0, 0, 0);
    endtask

    task automatic test_no_b();
        expect_fail(2'd1);
        drive(1, 0, 0);
        n_checks++;
        if ({busy, fail_pulse, fail_code} !== {1'b0, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL no_b: got busy=%0b f=%0b code=%0d want busy=0 f=1 code=1",
                     busy, fail_pulse, fail_code);
        end
        drive(1, 1, 0);
        n_checks++;
        if ({busy, fail_pulse} !== 2'b00) begin
            n_fail++;
            $display("FAIL late_b_ignored: got busy=%0b f=%0b want 0 0", busy, fail_pulse);
        end
        drive(0, 0, 0);
    endtask

    task automatic test_c_low();
        drive(1, 1, 0);
        drive(1, 0, 1);
        expect_fail(2'd3);
        drive(1, 0, 0);
        n_checks++;
        if ({fail_pulse, fail_code} !== {1'b1, 2'd3}) begin
            n_fail++;
            $display("FAIL c_low: got f=%0b code=%0d want f=1 code=3", fail_pulse, fail_code);
        end
        drive(0, 0, 0);
        drive(1, 1, 0);
        expect_fail(2'd2);
        drive(0, 0, 0);
        n_checks++;
        if ({fail_code, fail_count} !== {2'd2, 2'd3}) begin
            n_fail++;
            $display("FAIL a_over_c: got code=%0d fc=%0d want code=2 fc=3", fail_code, fail_count);
        end
        drive(0, 0, 0);
    endtask

    task automatic test_reset_mid_check();
        drive(1, 1, 0);
        rst = 1'b1;
        drive(1, 1, 1);
        exp_pc = 2'd0;
        exp_fc = 2'd0;
        exp_code = 2'd0;
        n_checks++;
        if ({busy, pass_pulse, fail_pulse, fail_code, pass_count, fail_count} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_mid_check: got busy=%0b p=%0b f=%0b code=%0d pc=%0d fc=%0d want all 0",
                     busy, pass_pulse, fail_pulse, fail_code, pass_count, fail_count);
        end
        rst = 1'b0;
        drive(1, 1, 0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL trigger_after_reset: got busy=%0b want 1", busy);
        end
        drive(1, 0, 1);
        expect_pass();
        drive(1, 0, 1);
        drive(0, 0, 0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            run_pass();
            n_checks++;
            if (pass_count !== exp_pc) begin
                n_fail++;
                $display("FAIL sat_count_%0d: got %0d want %0d", i, pass_count, exp_pc);
            end
        end
        n_checks++;
        if (pass_count !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_final: got %0d want 3", pass_count);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_a_drop();
        test_no_b();
        test_c_low();
        test_reset_mid_check();
        test_saturation();
        drive(0, 0, 0);
        drive(0, 0, 0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d unmatched expectations want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
